// File: rtl/u111_arb_pkg.sv
// u111_arb_pkg
// Shared definitions for the U111 local bus arbiter:
//   - arb_state_t : FSM state encodings (also exported on ARB_STATE)
//   - arb_out_t   : the three active-low bus control outputs as one record
//   - default parameter values for the arbiter and its synchronisers
//   - state_outputs(): output decode for each state
package u111_arb_pkg;

  typedef enum logic [2:0] {
    CPU_PARK = 3'd0,
    CPU_REL  = 3'd1,
    DMA_GNT  = 3'd2,
    DMA_OWN  = 3'd3,
    TURN     = 3'd4
  } arb_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_GNT_TIMEOUT    = 16;
  localparam int DEF_CPU_MIN_TENURE = 8;
  localparam int DEF_CNT_W          = 5;

  typedef struct packed {
    logic cpubg_n;
    logic dma_bg_n;
    logic dmaa_n;
  } arb_out_t;

  // Active-low output levels for each state. Every state drives at most one
  // grant, and DMA-active is only low while the CPU grant is high, so the
  // registered outputs can never show overlapping ownership.
  function automatic arb_out_t state_outputs(input arb_state_t s);
    arb_out_t o;
    o = '{cpubg_n: 1'b0, dma_bg_n: 1'b1, dmaa_n: 1'b1};
    case (s)
      CPU_PARK: o = '{cpubg_n: 1'b0, dma_bg_n: 1'b1, dmaa_n: 1'b1};
      CPU_REL:  o = '{cpubg_n: 1'b1, dma_bg_n: 1'b1, dmaa_n: 1'b1};
      DMA_GNT:  o = '{cpubg_n: 1'b1, dma_bg_n: 1'b0, dmaa_n: 1'b0};
      DMA_OWN:  o = '{cpubg_n: 1'b1, dma_bg_n: 1'b1, dmaa_n: 1'b0};
      TURN:     o = '{cpubg_n: 1'b1, dma_bg_n: 1'b1, dmaa_n: 1'b1};
      default:  o = '{cpubg_n: 1'b0, dma_bg_n: 1'b1, dmaa_n: 1'b1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/u111_sync.sv
// u111_sync
// Multi-flop synchroniser for one asynchronous input bit.
// Parameters:
//   STAGES    - number of flops in the chain (2..3)
//   RESET_VAL - value loaded into every flop while srst is high
// Ports:
//   clk  - sampling clock
//   srst - synchronous reset, active high
//   d    - asynchronous input
//   q    - synchronised output (last flop of the chain)
module u111_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/u111_bus_arbiter.sv
// u111_bus_arbiter
// Local bus arbiter sharing the 68040 bus between the CPU (parked owner) and
// an Amiga-side DMA master. Grants are withdrawn if the DMA master does not
// take the bus within GNT_TIMEOUT cycles, and the CPU keeps the bus for at
// least CPU_MIN_TENURE cycles after every DMA tenure.
// Ports:
//   CLK40     - 40 MHz bus clock, the only clock
//   RESET     - synchronous reset, active high
//   DMA_BRn   - DMA bus request, active low, asynchronous
//   BBn       - bus busy, active low, asynchronous
//   LOCKn     - 68040 locked cycle, active low, asynchronous
//   CPUBGn    - 68040 bus grant, active low (registered)
//   DMA_BGn   - DMA bus grant, active low (registered)
//   DMAAn     - DMA active / buffer steering, active low (registered)
//   ARB_STATE - current FSM state encoding (registered)
module u111_bus_arbiter
  import u111_arb_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int GNT_TIMEOUT    = DEF_GNT_TIMEOUT,
  parameter int CPU_MIN_TENURE = DEF_CPU_MIN_TENURE,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       CLK40,
  input  logic       RESET,
  input  logic       DMA_BRn,
  input  logic       BBn,
  input  logic       LOCKn,
  output logic       CPUBGn,
  output logic       DMA_BGn,
  output logic       DMAAn,
  output logic [2:0] ARB_STATE
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TENURE_LOAD  = CNT_W'(CPU_MIN_TENURE);

  // Raw asynchronous inputs, bit order {LOCKn, BBn, DMA_BRn}. All three are
  // active low, so every synchroniser resets to the negated level.
  logic [2:0] async_in;
  logic [2:0] sync_out;

  assign async_in = {LOCKn, BBn, DMA_BRn};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      u111_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
      ) u_sync (
        .clk  (CLK40),
        .srst (RESET),
        .d    (async_in[gi]),
        .q    (sync_out[gi])
      );
    end
  endgenerate

  // dma_req_s is active high; bb_s and lock_s keep the bus polarity
  // (1 = bus free / not locked).
  logic dma_req_s;
  logic bb_s;
  logic lock_s;

  assign dma_req_s = ~sync_out[0];
  assign bb_s      = sync_out[1];
  assign lock_s    = sync_out[2];

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  arb_out_t         out_reg;

  // One counter serves two purposes: in DMA_GNT it counts up towards the
  // grant timeout, and from TURN through CPU_PARK it counts the remaining
  // CPU tenure down to zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CPU_PARK: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
        if (dma_req_s && (cnt_reg == '0)) begin
          state_next = CPU_REL;
        end
      end
      CPU_REL: begin
        // A withdrawn request drops back without reloading the tenure, so a
        // re-request is honoured as soon as it is seen again.
        if (!dma_req_s) begin
          state_next = CPU_PARK;
        end else if (bb_s && lock_s) begin
          state_next = DMA_GNT;
          cnt_next   = '0;
        end
      end
      DMA_GNT: begin
        cnt_next = cnt_reg + 1'b1;
        // Bus taken outranks both request withdrawal and timeout.
        if (!bb_s) begin
          state_next = DMA_OWN;
        end else if (!dma_req_s) begin
          state_next = TURN;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = TURN;
        end
      end
      DMA_OWN: begin
        // Tenure ends only when the DMA master releases BBn.
        if (bb_s) begin
          state_next = TURN;
        end
      end
      TURN: begin
        cnt_next   = TENURE_LOAD;
        state_next = CPU_PARK;
      end
      default: begin
        state_next = CPU_PARK;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as ARB_STATE.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_reg <= CPU_PARK;
      cnt_reg   <= '0;
      out_reg   <= state_outputs(CPU_PARK);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= state_outputs(state_next);
    end
  end

  assign CPUBGn    = out_reg.cpubg_n;
  assign DMA_BGn   = out_reg.dma_bg_n;
  assign DMAAn     = out_reg.dmaa_n;
  assign ARB_STATE = state_reg;

endmodule
